// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern engine.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_WATER   = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Width of the position index for a given channel count (at least 1 bit).
  function automatic int pos_width(input int num_leds);
    return (num_leds < 2) ? 1 : $clog2(num_leds);
  endfunction

endpackage

// File: rtl/pwm_dimmer.sv
// PWM dimmer: free-running PWM counter, saturating brightness register and
// duty shaping. Define LED_PATTERN_GAMMA_EN to apply a quadratic gamma map
// to the duty; otherwise the duty is linear.
module pwm_dimmer #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [PWM_BITS-1:0] level_cap,
  input  logic                up_pulse,
  input  logic                down_pulse,
  output logic                on
);

  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] brightness;
  logic [PWM_BITS-1:0] duty_lin;
  logic [PWM_BITS-1:0] duty;

  // Saturating brightness adjust; opposing pulses in the same cycle cancel.
  function automatic logic [PWM_BITS-1:0] sat_adjust(input logic [PWM_BITS-1:0] b,
                                                     input logic up,
                                                     input logic dn);
    logic [PWM_BITS-1:0] r;
    r = b;
    if (up && !dn && (b != MAX)) r = b + 1'b1;
    else if (dn && !up && (b != '0)) r = b - 1'b1;
    return r;
  endfunction

`ifdef LED_PATTERN_GAMMA_EN
  // Quadratic perceptual map; full scale stays full scale so MAX is still solid on.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = d * d;
    if (d == MAX) return MAX;
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  // Free-running PWM period counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pwm_cnt <= '0;
    else           pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Brightness register, adjusted by the pre-debounced pulses even while paused.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) brightness <= MAX;
    else           brightness <= sat_adjust(brightness, up_pulse, down_pulse);
  end

  // Duty is the brightness limited by the caller's level cap, then shaped.
  always_comb begin
    duty_lin = (level_cap < brightness) ? level_cap : brightness;
`ifdef LED_PATTERN_GAMMA_EN
    duty = gamma_map(duty_lin);
`else
    duty = duty_lin;
`endif
  end

  assign on = (pwm_cnt < duty) || (duty == MAX);

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-channel LED pattern engine: water, bounce, blink and breathe patterns
// with programmable step period, pause and PWM brightness. Active-low LED
// outputs are registered. LED_PATTERN_GAMMA_EN (in pwm_dimmer) selects a
// gamma-mapped duty.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int STEP_UNIT = 750000,
  parameter int PWM_BITS  = 4,
  localparam int POS_W    = pos_width(NUM_LEDS)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [1:0]          mode,
  input  logic [3:0]          speed,
  input  logic                dir,
  input  logic                pause,
  input  logic                up_pulse,
  input  logic                down_pulse,
  output logic [NUM_LEDS-1:0] led_n,
  output logic [POS_W-1:0]    pos,
  output logic                step_pulse
);

  localparam int                  CNT_W   = $clog2(STEP_UNIT * 16);
  localparam logic [POS_W-1:0]    LAST    = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    LAST_M1 = POS_W'(NUM_LEDS - 2);
  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};

  mode_e               active_mode;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    period_m1;
  logic                mode_chg;
  logic                terminal;
  logic                bounce_up;
  logic                breathe_up;
  logic                blink_phase;
  logic [PWM_BITS-1:0] breathe_lvl;

  logic [POS_W-1:0]    pos_nxt;
  logic                bounce_up_nxt;
  logic                breathe_up_nxt;
  logic                blink_nxt;
  logic [PWM_BITS-1:0] lvl_nxt;

  logic [PWM_BITS-1:0] level_cap;
  logic                on;
  logic [NUM_LEDS-1:0] led_nxt;

  // A step lasts STEP_UNIT*(speed+1) cycles; >= lets a lowered speed end the step at once.
  assign period_m1 = CNT_W'(STEP_UNIT * (int'(speed) + 1) - 1);
  assign terminal  = (cnt >= period_m1);
  assign mode_chg  = (mode != active_mode);

  // Pattern state to adopt on the next step.
  always_comb begin
    pos_nxt        = pos;
    bounce_up_nxt  = bounce_up;
    breathe_up_nxt = breathe_up;
    blink_nxt      = blink_phase;
    lvl_nxt        = breathe_lvl;
    case (active_mode)
      MODE_WATER: begin
        if (dir) pos_nxt = (pos == LAST) ? '0 : pos + 1'b1;
        else     pos_nxt = (pos == '0) ? LAST : pos - 1'b1;
      end
      MODE_BOUNCE: begin
        if (bounce_up) begin
          if (pos == LAST) begin
            bounce_up_nxt = 1'b0;
            pos_nxt       = LAST_M1;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            bounce_up_nxt = 1'b1;
            pos_nxt       = POS_W'(1);
          end else begin
            pos_nxt = pos - 1'b1;
          end
        end
      end
      MODE_BLINK: blink_nxt = ~blink_phase;
      default: begin
        if (breathe_up) begin
          if (breathe_lvl == MAX) begin
            breathe_up_nxt = 1'b0;
            lvl_nxt        = MAX - 1'b1;
          end else begin
            lvl_nxt = breathe_lvl + 1'b1;
          end
        end else begin
          if (breathe_lvl == '0) begin
            breathe_up_nxt = 1'b1;
            lvl_nxt        = PWM_BITS'(1);
          end else begin
            lvl_nxt = breathe_lvl - 1'b1;
          end
        end
      end
    endcase
  end

  // Step counter and pattern state; a mode change restarts everything and skips the step.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_mode <= MODE_WATER;
      cnt         <= '0;
      step_pulse  <= 1'b0;
      pos         <= '0;
      bounce_up   <= 1'b1;
      breathe_up  <= 1'b1;
      breathe_lvl <= '0;
      blink_phase <= 1'b0;
    end else if (mode_chg) begin
      active_mode <= mode_e'(mode);
      cnt         <= '0;
      step_pulse  <= 1'b0;
      pos         <= '0;
      bounce_up   <= 1'b1;
      breathe_up  <= 1'b1;
      breathe_lvl <= '0;
      blink_phase <= 1'b0;
    end else if (pause) begin
      step_pulse <= 1'b0;
    end else if (terminal) begin
      cnt         <= '0;
      step_pulse  <= 1'b1;
      pos         <= pos_nxt;
      bounce_up   <= bounce_up_nxt;
      breathe_up  <= breathe_up_nxt;
      breathe_lvl <= lvl_nxt;
      blink_phase <= blink_nxt;
    end else begin
      cnt        <= cnt + 1'b1;
      step_pulse <= 1'b0;
    end
  end

  // Only breathe limits the duty by its ramp level; other modes use plain brightness.
  assign level_cap = (active_mode == MODE_BREATHE) ? breathe_lvl : MAX;

  pwm_dimmer #(
    .PWM_BITS (PWM_BITS)
  ) u_dimmer (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .level_cap  (level_cap),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .on         (on)
  );

  // Active-low LED image for the current pattern state.
  always_comb begin
    led_nxt = '1;
    case (active_mode)
      MODE_WATER, MODE_BOUNCE: led_nxt[pos] = ~on;
      MODE_BLINK:              led_nxt = {NUM_LEDS{~(on & blink_phase)}};
      default:                 led_nxt = {NUM_LEDS{~on}};
    endcase
  end

  // Output register stage driving the LED pins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) led_n <= '1;
    else           led_n <= led_nxt;
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (NUM_LEDS=8, STEP_UNIT=4, PWM_BITS=4).
module tb_led_pattern_engine;

  localparam int N    = 8;
  localparam int UNIT = 4;
  localparam int MAXV = 15;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] speed = 4'd0;
  logic       dir = 1'b1;
  logic       pause = 1'b0;
  logic       up_pulse = 1'b0;
  logic       down_pulse = 1'b0;
  logic [7:0] led_n;
  logic [2:0] pos;
  logic       step_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: steps are counted since the last mode entry and
  // positions/levels are derived from that count arithmetically.
  int         m_mode, m_cnt, m_k, m_wpos, m_bright, m_pwm;
  logic       m_step;
  logic [7:0] m_led;

  led_pattern_engine #(.NUM_LEDS(N), .STEP_UNIT(UNIT), .PWM_BITS(4)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .mode       (mode),
    .speed      (speed),
    .dir        (dir),
    .pause      (pause),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .led_n      (led_n),
    .pos        (pos),
    .step_pulse (step_pulse)
  );

  always #5 clk_in = ~clk_in;

  function automatic int fold(input int k, input int half);
    int r;
    r = k % (2 * half);
    return (r <= half) ? r : 2 * half - r;
  endfunction

  function automatic int model_pos();
    if (m_mode == 0) return m_wpos;
    if (m_mode == 1) return fold(m_k, N - 1);
    return 0;
  endfunction

  function automatic logic [7:0] model_led();
    int d;
    int lvl;
    logic on;
    logic [7:0] r;
    lvl = fold(m_k, MAXV);
    d = m_bright;
    if (m_mode == 3 && lvl < d) d = lvl;
`ifdef LED_PATTERN_GAMMA_EN
    if (d != MAXV) d = (d * d) / 16;
`endif
    on = (m_pwm < d) || (d == MAXV);
    r = 8'hFF;
    case (m_mode)
      0, 1: r[model_pos()] = ~on;
      2:    r = {8{~(on & (m_k % 2 == 1))}};
      default: r = {8{~on}};
    endcase
    return r;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_mode <= 0; m_cnt <= 0; m_k <= 0; m_wpos <= 0; m_bright <= MAXV;
      m_pwm <= 0; m_step <= 1'b0; m_led <= 8'hFF;
    end else begin
      m_led <= model_led();
      m_pwm <= (m_pwm + 1) % 16;
      if (up_pulse && !down_pulse && m_bright < MAXV) m_bright <= m_bright + 1;
      else if (down_pulse && !up_pulse && m_bright > 0) m_bright <= m_bright - 1;
      if (int'(mode) != m_mode) begin
        m_mode <= int'(mode); m_cnt <= 0; m_k <= 0; m_wpos <= 0; m_step <= 1'b0;
      end else if (pause) begin
        m_step <= 1'b0;
      end else if (m_cnt >= UNIT * (int'(speed) + 1) - 1) begin
        m_cnt <= 0; m_step <= 1'b1; m_k <= m_k + 1;
        if (m_mode == 0) m_wpos <= dir ? (m_wpos + 1) % N : (m_wpos + N - 1) % N;
      end else begin
        m_cnt <= m_cnt + 1; m_step <= 1'b0;
      end
    end
  end

  task automatic pulse_brightness(input logic u, input logic d, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk_in); up_pulse = u; down_pulse = d;
      @(negedge clk_in); up_pulse = 1'b0; down_pulse = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_tests++; if (led_n !== 8'hFF) begin n_fail++; $display("FAIL reset_led got=%h exp=ff", led_n); end
    n_tests++; if (pos !== 3'd0) begin n_fail++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step got=%b exp=0", step_pulse); end
    rst_n_in = 1'b1;
  endtask

  task automatic test_water();
    int last_step;
    int prev_pos;
    last_step = -1; prev_pos = 0;
    mode = 2'd0; speed = 4'd0; dir = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      n_tests++; if (pos !== 3'(model_pos())) begin n_fail++; $display("FAIL water_pos cyc=%0d got=%0d exp=%0d", c, pos, model_pos()); end
      n_tests++; if (step_pulse !== m_step) begin n_fail++; $display("FAIL water_step cyc=%0d got=%b exp=%b", c, step_pulse, m_step); end
      n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL water_led cyc=%0d got=%h exp=%h", c, led_n, m_led); end
      if (step_pulse === 1'b1) begin
        n_tests++; if (int'(pos) != (prev_pos + 1) % N) begin n_fail++; $display("FAIL water_inc got=%0d exp=%0d", pos, (prev_pos + 1) % N); end
        if (last_step >= 0) begin
          n_tests++; if (c - last_step != UNIT) begin n_fail++; $display("FAIL water_period got=%0d exp=%0d", c - last_step, UNIT); end
        end
        last_step = c; prev_pos = int'(pos);
      end
    end
  endtask

  task automatic test_bounce();
    @(negedge clk_in); mode = 2'd1; speed = 4'd1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk_in);
      n_tests++; if (pos !== 3'(model_pos())) begin n_fail++; $display("FAIL bounce_pos cyc=%0d got=%0d exp=%0d", c, pos, model_pos()); end
      n_tests++; if (step_pulse !== m_step) begin n_fail++; $display("FAIL bounce_step cyc=%0d got=%b exp=%b", c, step_pulse, m_step); end
      n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL bounce_led cyc=%0d got=%h exp=%h", c, led_n, m_led); end
      dir = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_water_reverse_pause();
    bit seen;
    seen = 1'b0;
    @(negedge clk_in); mode = 2'd0; dir = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk_in);
      if (step_pulse === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL reverse_timeout got=no_step exp=step"); end
    n_tests++; if (pos !== 3'd7) begin n_fail++; $display("FAIL reverse_wrap got=%0d exp=7", pos); end
    pause = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      n_tests++; if (pos !== 3'd7) begin n_fail++; $display("FAIL pause_pos cyc=%0d got=%0d exp=7", c, pos); end
      n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL pause_step cyc=%0d got=%b exp=0", c, step_pulse); end
      n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL pause_led cyc=%0d got=%h exp=%h", c, led_n, m_led); end
    end
    pause = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      n_tests++; if (pos !== 3'(model_pos())) begin n_fail++; $display("FAIL resume_pos cyc=%0d got=%0d exp=%0d", c, pos, model_pos()); end
      n_tests++; if (step_pulse !== m_step) begin n_fail++; $display("FAIL resume_step cyc=%0d got=%b exp=%b", c, step_pulse, m_step); end
    end
  endtask

  task automatic test_brightness();
    int lows;
    int exp_lows [4];
`ifdef LED_PATTERN_GAMMA_EN
    exp_lows = '{0, 0, 0, 4};
`else
    exp_lows = '{0, 3, 3, 8};
`endif
    pause = 1'b1;
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0: pulse_brightness(1'b0, 1'b1, 16);
        1: pulse_brightness(1'b1, 1'b0, 3);
        2: pulse_brightness(1'b1, 1'b1, 2);
        default: pulse_brightness(1'b1, 1'b0, 5);
      endcase
      repeat (2) @(negedge clk_in);
      lows = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk_in);
        if (led_n !== 8'hFF) lows++;
        n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL bright_led ph=%0d got=%h exp=%h", phase, led_n, m_led); end
      end
      n_tests++; if (lows != exp_lows[phase]) begin n_fail++; $display("FAIL bright_duty ph=%0d got=%0d exp=%0d", phase, lows, exp_lows[phase]); end
    end
    pause = 1'b0;
  endtask

  task automatic test_breathe();
    pulse_brightness(1'b1, 1'b0, 16);
    @(negedge clk_in); mode = 2'd3; speed = 4'd0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk_in);
      n_tests++; if (step_pulse !== m_step) begin n_fail++; $display("FAIL breathe_step cyc=%0d got=%b exp=%b", c, step_pulse, m_step); end
      n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL breathe_led cyc=%0d got=%h exp=%h", c, led_n, m_led); end
      if (c >= 60 && c < 80) down_pulse = (c % 2 == 0);
      else down_pulse = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_in);
      n_tests++; if (pos !== 3'(model_pos())) begin n_fail++; $display("FAIL rand_pos cyc=%0d got=%0d exp=%0d", c, pos, model_pos()); end
      n_tests++; if (step_pulse !== m_step) begin n_fail++; $display("FAIL rand_step cyc=%0d got=%b exp=%b", c, step_pulse, m_step); end
      n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL rand_led cyc=%0d got=%h exp=%h", c, led_n, m_led); end
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) speed = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      dir        = 1'($urandom_range(0, 1));
      up_pulse   = ($urandom_range(0, 9) == 0);
      down_pulse = ($urandom_range(0, 9) == 0);
    end
    up_pulse = 1'b0; down_pulse = 1'b0; pause = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk_in); mode = 2'd0; speed = 4'd0; dir = 1'b1;
    repeat (11) @(negedge clk_in);
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    n_tests++; if (led_n !== 8'hFF) begin n_fail++; $display("FAIL async_led got=%h exp=ff", led_n); end
    n_tests++; if (pos !== 3'd0) begin n_fail++; $display("FAIL async_pos got=%0d exp=0", pos); end
    n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL async_step got=%b exp=0", step_pulse); end
    @(negedge clk_in); rst_n_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      n_tests++; if (pos !== 3'(model_pos())) begin n_fail++; $display("FAIL post_reset_pos cyc=%0d got=%0d exp=%0d", c, pos, model_pos()); end
      n_tests++; if (led_n !== m_led) begin n_fail++; $display("FAIL post_reset_led cyc=%0d got=%h exp=%h", c, led_n, m_led); end
    end
  endtask

  initial begin
    test_reset();
    test_water();
    test_bounce();
    test_water_reverse_pause();
    test_brightness();
    test_breathe();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
